jk_register_bank: RTL

Parametrised bank of WIDTH JK flip-flops sharing one clock, with three extra whole-word modes: parallel load, up/down binary counting, and serial shift. It is the multi-bit successor to the single JK flip-flop cell. It serves as a general-purpose state register, counter or shift register in lab datapaths. Q and Qbar are always bitwise complements.

---
 rtl/jk_register_bank.sv | 88 ++++++++
 1 files changed

// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK flip-flops with whole-word LOAD, up/down COUNT and SHIFT modes.
// Q/Qbar are registered as a complementary pair; tc is combinational for cascading.
module jk_register_bank #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
    input  logic             up,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             tc,
    output logic             changed
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_COUNT = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qbar;
    logic             r_changed;

    logic [WIDTH-1:0] w_jk_next;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_q_next;

    always_comb begin
        w_jk_next = r_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            unique case ({J[i], K[i]})
                2'b00:   w_jk_next[i] = r_q[i];
                2'b01:   w_jk_next[i] = 1'b0;
                2'b10:   w_jk_next[i] = 1'b1;
                default: w_jk_next[i] = ~r_q[i];
            endcase
        end
    end

    // Ripple toggle chain: bit i toggles when all lower bits are ones (up) or zeros (down).
    always_comb begin
        logic w_run;
        w_toggle = '0;
        w_run    = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_toggle[i] = w_run;
            w_run       = w_run & (up ? r_q[i] : ~r_q[i]);
        end
    end

    always_comb begin
        w_q_next = r_q;
        unique case (mode)
            MODE_JK:    w_q_next = w_jk_next;
            MODE_LOAD:  w_q_next = D;
            MODE_COUNT: w_q_next = r_q ^ w_toggle;
            MODE_SHIFT: w_q_next = {r_q[WIDTH-2:0], sin};
            default:    w_q_next = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q       <= RESET_VALUE;
            r_qbar    <= ~RESET_VALUE;
            r_changed <= 1'b0;
        end else if (!en) begin
            r_changed <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_qbar    <= ~w_q_next;
            r_changed <= (w_q_next != r_q);
        end
    end

    assign tc      = en & (mode == MODE_COUNT) & (up ? (&r_q) : ~(|r_q));
    assign Q       = r_q;
    assign Qbar    = r_qbar;
    assign changed = r_changed;

endmodule
